// File: rtl/tt_sweep_ctrl.sv
// tt_sweep_ctrl: truth-table sweep sequencer for a 3-input, 1-output logic block.
// Drives rows 000..111, settles, samples, builds an 8-bit code (row 000 = MSB),
// and compares it against EXPECTED.
// Optional feature macro: TT_SWEEP_STABLE_CHECK_EN. When it is defined, the
// block output is also registered on the last settle cycle of each row, and a
// row is flagged unstable if the output moved between that cycle and the
// sample cycle.

module tt_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter logic [7:0]  EXPECTED      = 8'hDA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_out,
  output logic [2:0] dut_in,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] result,
  output logic [7:0] fail_mask,
  output logic [7:0] unstable_mask
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned ROW_W = 3;
  localparam int unsigned TT_W  = 8;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(7);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ROW_W-1:0]  row_q;
  logic              busy_q;
  logic              done_q;
  logic              pass_q;
  logic [TT_W-1:0]   result_q;
  logic [TT_W-1:0]   fail_q;

  logic [ROW_W-1:0]  bit_idx_c;
  logic [TT_W-1:0]   result_d;
  logic              pass_d;

`ifdef TT_SWEEP_STABLE_CHECK_EN
  logic              settle_ref_q;
  logic [TT_W-1:0]   unstable_q;
  logic [TT_W-1:0]   unstable_d;
`endif

  // Row k lands in bit 7-k so that row 000 becomes the MSB of the code
  assign bit_idx_c = LAST_ROW - row_q;

  // Result, stability mask and verdict as they will be after this row's sample
  always_comb begin
    result_d            = result_q;
    result_d[bit_idx_c] = dut_out;
`ifdef TT_SWEEP_STABLE_CHECK_EN
    unstable_d = unstable_q;
    if (dut_out != settle_ref_q) begin
      unstable_d[bit_idx_c] = 1'b1;
    end
    pass_d = (result_d == EXPECTED) && (unstable_d == '0);
`else
    pass_d = (result_d == EXPECTED);
`endif
  end

  // Sweep sequencer: state, settle counter, row index and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      row_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= '0;
      fail_q   <= '0;
`ifdef TT_SWEEP_STABLE_CHECK_EN
      settle_ref_q <= 1'b0;
      unstable_q   <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q  <= ST_SETTLE;
            cnt_q    <= CNT_RELOAD;
            row_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            result_q <= '0;
            fail_q   <= '0;
`ifdef TT_SWEEP_STABLE_CHECK_EN
            unstable_q <= '0;
`endif
          end
        end

        ST_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= ST_SAMPLE;
`ifdef TT_SWEEP_STABLE_CHECK_EN
            settle_ref_q <= dut_out;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end

        ST_SAMPLE: begin
          result_q <= result_d;
`ifdef TT_SWEEP_STABLE_CHECK_EN
          unstable_q <= unstable_d;
`endif
          if (row_q != LAST_ROW) begin
            row_q   <= row_q + ROW_W'(1);
            cnt_q   <= CNT_RELOAD;
            state_q <= ST_SETTLE;
          end else begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= pass_d;
            fail_q  <= result_d ^ EXPECTED;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Output mapping
  assign dut_in    = row_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign fail_mask = fail_q;

`ifdef TT_SWEEP_STABLE_CHECK_EN
  assign unstable_mask = unstable_q;
`else
  assign unstable_mask = '0;
`endif

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Bench for tt_sweep_ctrl: two instances (settle 4 and settle 1) sweeping
// modelled 3-input blocks; expectations are queued at start and popped when done rises.

module tb_tt_sweep_ctrl;

  localparam int         S_A   = 4;
  localparam int         S_B   = 1;
  localparam int         N_A   = 8 * (S_A + 1);
  localparam int         N_B   = 8 * (S_B + 1);
  localparam logic [7:0] EXP_A = 8'hDA;
  localparam logic [7:0] EXP_B = 8'h96;

  typedef struct packed {
    logic [7:0] result;
    logic [7:0] fail_mask;
    logic [7:0] unst;
    logic       pass;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;

  logic       dut_out_a, dut_out_b;
  logic [2:0] dut_in_a, dut_in_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] result_a, result_b, fail_a, fail_b, unst_a, unst_b;

  logic [7:0] code_a, code_b;
  int         glitch_cyc_a;
  int         cyc_a, cyc_b;
  bit         act_a, act_b;
  logic       done_prev_a = 1'b0;
  logic       done_prev_b = 1'b0;

  exp_t       q_a[$];
  exp_t       q_b[$];

  int         n_chk;
  int         n_fail;

  always #5 clk = ~clk;

  tt_sweep_ctrl #(.SETTLE_CYCLES(S_A), .EXPECTED(EXP_A)) u_a (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out_a),
    .dut_in(dut_in_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .result(result_a), .fail_mask(fail_a), .unstable_mask(unst_a)
  );

  tt_sweep_ctrl #(.SETTLE_CYCLES(S_B), .EXPECTED(EXP_B)) u_b (
    .clk(clk), .rst(rst), .start(start), .dut_out(dut_out_b),
    .dut_in(dut_in_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .result(result_b), .fail_mask(fail_b), .unstable_mask(unst_b)
  );

  // Block under characterization: Wolfram code, row k = {in1,in2,in3} gives code bit 7-k
  function automatic logic block_out(input logic [7:0] code, input logic [2:0] row);
    logic [2:0] idx;
    idx = 3'd7 - row;
    return code[idx];
  endfunction

  assign dut_out_a = block_out(code_a, dut_in_a) ^ (act_a && (cyc_a == glitch_cyc_a));
  assign dut_out_b = block_out(code_b, dut_in_b);

  // Expected outcome of one whole sweep, computed row by row from the block model
  function automatic exp_t ref_model(input logic [7:0] code, input logic [7:0] expv,
                                     input int glitch_row);
    exp_t       e;
    logic [7:0] res;
    logic [7:0] unst;
    logic       o;
    logic       flag;
    res  = '0;
    unst = '0;
    for (int k = 0; k < 8; k++) begin
      o    = block_out(code, 3'(k));
      flag = 1'b0;
      if (k == glitch_row) begin
        o = ~o;
`ifdef TT_SWEEP_STABLE_CHECK_EN
        flag = 1'b1;
`endif
      end
      res  = {res[6:0], o};
      unst = {unst[6:0], flag};
    end
    e.result    = res;
    e.fail_mask = res ^ expv;
    e.unst      = unst;
    e.pass      = (res == expv) && (unst == 8'h00);
    return e;
  endfunction

  // Cycle count since each instance's accepted start (model of when start is honoured)
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_a <= 1'b0;
      cyc_a <= 0;
    end else if (start && !(act_a && cyc_a < N_A)) begin
      act_a <= 1'b1;
      cyc_a <= 0;
    end else if (act_a) begin
      cyc_a <= cyc_a + 1;
    end
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      act_b <= 1'b0;
      cyc_b <= 0;
    end else if (start && !(act_b && cyc_b < N_B)) begin
      act_b <= 1'b1;
      cyc_b <= 0;
    end else if (act_b) begin
      cyc_b <= cyc_b + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int id, input int n, input int s, input bit act, input int cyc,
                     input logic [2:0] di, input logic bsy, input logic dn, input logic dn_prev,
                     input logic ps, input logic [7:0] res, input logic [7:0] fm,
                     input logic [7:0] um);
    exp_t e;
    bit   have;
    if (!act) return;
    chk($sformatf("busy%0d c%0d", id, cyc), 32'(bsy), 32'(cyc < n));
    chk($sformatf("done%0d c%0d", id, cyc), 32'(dn), 32'(cyc >= n));
    chk($sformatf("dut_in%0d c%0d", id, cyc), 32'(di), 32'((cyc < n) ? cyc / (s + 1) : 7));
    if (dn && !dn_prev) begin
      have = 1'b0;
      if (id == 0 && q_a.size() > 0) begin
        e = q_a.pop_front();
        have = 1'b1;
      end else if (id == 1 && q_b.size() > 0) begin
        e = q_b.pop_front();
        have = 1'b1;
      end
      chk($sformatf("sb_has_entry%0d", id), 32'(have), 32'(1));
      if (have) begin
        chk($sformatf("done_cycle%0d", id), 32'(cyc), 32'(n));
        chk($sformatf("result%0d", id), 32'(res), 32'(e.result));
        chk($sformatf("fail_mask%0d", id), 32'(fm), 32'(e.fail_mask));
        chk($sformatf("unstable%0d", id), 32'(um), 32'(e.unst));
        chk($sformatf("pass%0d", id), 32'(ps), 32'(e.pass));
      end
    end
  endtask

  // Monitor: sample on the falling edge, away from the DUT's active edge
  always @(negedge clk) begin
    if (!rst) begin
      mon(0, N_A, S_A, act_a, cyc_a, dut_in_a, busy_a, done_a, done_prev_a, pass_a,
          result_a, fail_a, unst_a);
      mon(1, N_B, S_B, act_b, cyc_b, dut_in_b, busy_b, done_b, done_prev_b, pass_b,
          result_b, fail_b, unst_b);
    end
    done_prev_a = done_a;
    done_prev_b = done_b;
  end

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_a"}, 32'({dut_in_a, busy_a, done_a, pass_a, result_a, fail_a, unst_a}), 32'(0));
    chk({tag, "_b"}, 32'({dut_in_b, busy_b, done_b, pass_b, result_b, fail_b, unst_b}), 32'(0));
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 2 * N_A; i++) begin
      @(negedge clk);
      if (done_a && done_b) begin
        ok = 1'b1;
        break;
      end
    end
    chk("sweep_completes", 32'(ok), 32'(1));
  endtask

  task automatic issue_start(input logic [7:0] ca, input logic [7:0] cb, input int grow);
    code_a       = ca;
    code_b       = cb;
    glitch_cyc_a = (grow < 0) ? -1 : grow * (S_A + 1) + S_A;
    q_a.push_back(ref_model(ca, EXP_A, grow));
    q_b.push_back(ref_model(cb, EXP_B, -1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sweep(input logic [7:0] ca, input logic [7:0] cb, input int grow,
                       input bit poke);
    int gap;
    gap = int'($urandom_range(0, 3));
    repeat (gap) @(negedge clk);
    issue_start(ca, cb, grow);
    if (poke) begin
      repeat (11) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    int grow;
    n_chk        = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    code_a       = 8'hDA;
    code_b       = 8'hDA;
    glitch_cyc_a = -1;

    repeat (3) @(negedge clk);
    chk_reset_outs("reset_vals");
    rst = 1'b0;
    @(negedge clk);

    // Nominal 0xDA block; second instance checks a non-default expected code
    sweep(8'hDA, 8'hDA, -1, 1'b0);
    sweep(8'hDB, EXP_B, -1, 1'b0);

    // Second start mid-sweep is ignored
    sweep(8'hDA, 8'($urandom), -1, 1'b1);

    // Reset during row 3 of the slow instance, then a clean sweep
    issue_start(8'hDA, 8'hDA, -1);
    repeat (17) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk_reset_outs("async_reset");
    q_a.delete();
    q_b.delete();
    repeat (3) @(negedge clk);
    chk_reset_outs("held_reset");
    rst = 1'b0;
    @(negedge clk);
    sweep(8'hDA, 8'hDA, -1, 1'b0);

    // Row 5 output moves during its sample cycle
    sweep(8'hDA, 8'hDA, 5, 1'b0);

    // Random blocks, occasional moving row
    for (int i = 0; i < 8; i++) begin
      grow = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
      sweep(8'($urandom), 8'($urandom), grow, 1'b0);
    end

    repeat (4) @(negedge clk);
    chk("sb_drained_a", 32'(q_a.size()), 32'(0));
    chk("sb_drained_b", 32'(q_b.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_ctrl.md
# tt_sweep_ctrl

Sequencer that exhaustively characterizes a 3-input, 1-output combinational logic block such as a Wolfram-coded gate module. On a start pulse it drives all 8 input rows in ascending order, waits a programmable settle time per row, samples the block's output, and assembles an 8-bit truth-table code. It then compares that code against an expected code and reports pass/fail with a per-row mismatch mask. It sits between the test/control host and the logic-function module under characterization.

## Interface
- `SETTLE_CYCLES`, default 4: cycles each row is held before sampling; legal range 1..255.
- `EXPECTED`, default 8'hDA: expected truth-table code (Wolfram convention).
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin sweep; sampled only when `busy`=0.
- `dut_out` input 1: output of the block under test.
- `dut_in` output 3: row drive; bit2→in1, bit1→in2, bit0→in3.
- `busy` output 1: sweep in progress.
- `done` output 1: sweep complete; level, held until next accepted `start`.
- `pass` output 1: `result`==`EXPECTED` and no unstable rows; valid when `done`=1.
- `result` output 8: captured truth-table code.
- `fail_mask` output 8: `result` ^ `EXPECTED`.
- `unstable_mask` output 8: rows whose output changed at the sample point (see Configuration).

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE/DONE, `start`=1: clear `result`, `unstable_mask`, `done`, `pass`; set row k=0, `dut_in`=0, settle counter=SETTLE_CYCLES-1; go SETTLE; `busy`=1.
- SETTLE: counter decrements each cycle; when it is 0, go SAMPLE.
- SAMPLE: capture `dut_out` into `result[7-k]` (row k={in1,in2,in3} maps to bit 7-k, so row 000 is the MSB). If k<7: k++, `dut_in`=k+1, reload counter, go SETTLE. If k==7: go DONE.
- DONE: `busy`=0, `done`=1, `pass` and `fail_mask` updated from the final `result`. `dut_in` holds 3'b111.
- `start` while `busy`=1 is ignored; no restart and no abort.
- Counter width is $clog2(SETTLE_CYCLES+1); row index is 3 bits. Wrap is prevented by the k==7 exit.

## Timing
- Reset values: `dut_in`=0, `busy`=0, `done`=0, `pass`=0, `result`=0, `fail_mask`=0, `unstable_mask`=0; state=IDLE.
- Cycle 0 is the edge on which `start` is accepted. `busy`=1 and `dut_in`=0 are visible from cycle 0.
- Each row lasts SETTLE_CYCLES+1 cycles: SETTLE_CYCLES in SETTLE plus 1 in SAMPLE. `dut_out` is sampled on the edge that leaves SAMPLE, i.e. SETTLE_CYCLES+1 edges after `dut_in` changed.
- `done`=1, `busy`=0 from cycle 8×(SETTLE_CYCLES+1). This is 40 cycles at the default.
- `start` asserted in the same cycle that DONE is entered is not seen until the next cycle.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous). No partial result is retained.

## Configuration
- `TT_SWEEP_STABLE_CHECK_EN` defined:
  - `dut_out` is also registered on the final SETTLE cycle of each row.
  - In SAMPLE, if `dut_out` differs from that registered value, set `unstable_mask[7-k]`.
  - `pass` additionally requires `unstable_mask`==0.
- Not defined: `unstable_mask` is tied to 0, no extra register exists, and `pass` depends only on `result`.

## Test plan
- DUT model = 0xDA function, SETTLE_CYCLES=4, pulse `start` → `dut_in` steps 0..7 every 5 cycles; `done` at cycle 40; `result`=8'hDA, `fail_mask`=0, `pass`=1.
- DUT model = 0xDB function → `result`=8'hDB, `fail_mask`=8'h01, `pass`=0.
- Pulse `start` again at cycle 12 of a sweep → ignored; completion still at cycle 40, `result` unchanged from the single-sweep case.
- Assert `rst` during row 3, then release and restart → all outputs 0 during reset; the new sweep completes in 40 cycles with `result`=8'hDA.
- SETTLE_CYCLES=1 → rows every 2 cycles; `done` at cycle 16; `result`=8'hDA.
- With `TT_SWEEP_STABLE_CHECK_EN`, the DUT output for row 5 toggles on its SAMPLE cycle → `unstable_mask`=8'h04, `pass`=0. Without the macro, `unstable_mask`=0.
